// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package arb_pkg;

    // Arbiter FSM states: no owner, or one requester holding the grant
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Binary index of the set bit in a one-hot vector (up to 64 requesters);
    // returns 0 for an all-zero vector
    function automatic logic [5:0] onehot_to_idx(input logic [63:0] oneHot);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < 64; i++) begin
            if (oneHot[i]) begin
                idx = 6'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requester blocks and the arbiter.
interface rr_arbiter_if #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
);
    import arb_pkg::*;

    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             preempted;

    // Requester side: raises requests and releases the resource
    modport master (
        output req,
        output done,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  preempted
    );

    // Arbiter side: samples requests and drives the select lines
    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_idx,
        output grant_valid,
        output preempted
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: the first set request at or after ptr wins.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_win_idx,
    output logic             o_win_valid
);

    logic [2*N-1:0] w_reqDbl;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_rotOh;
    logic [2*N-1:0] w_ohDbl;
    logic [N-1:0]   w_winOh;

    // Rotate so ptr lands on bit 0, keep the lowest set bit, rotate back
    always_comb begin
        w_reqDbl    = {i_req, i_req} >> i_ptr;
        w_rot       = w_reqDbl[N-1:0];
        w_rotOh     = w_rot & (~w_rot + {{(N-1){1'b0}}, 1'b1});
        w_ohDbl     = {w_rotOh, w_rotOh} << i_ptr;
        w_winOh     = w_ohDbl[2*N-1:N];
        o_win_idx   = IDX_W'(onehot_to_idx(64'(w_winOh)));
        o_win_valid = |i_req;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered grant held until done, request drop,
// or the hold limit; re-arbitration on release is back-to-back.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic         clk,
    input  logic         reset,
    rr_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(N);
    localparam int HC_W  = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_START = (MAX_HOLD == 0) ? '0 : HC_W'(1);

    arb_state_t       r_state;
    logic [N-1:0]     r_grant;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic             r_preempted;
    logic [IDX_W-1:0] r_ptr;
    logic [HC_W-1:0]  r_holdCnt;

    logic             w_busy;
    logic             w_ownerReq;
    logic             w_limit;
    logic             w_release;
    logic             w_forced;
    logic [IDX_W-1:0] w_nextPtr;
    logic [IDX_W-1:0] w_pickPtr;
    logic [IDX_W-1:0] w_winIdx;
    logic             w_winValid;

    // Release conditions for the current owner and the pointer to search from;
    // a forced release is one where only the hold limit ended the grant
    always_comb begin
        w_busy     = (r_state == BUSY);
        w_ownerReq = bus.req[r_idx];
        w_limit    = (MAX_HOLD != 0) && (r_holdCnt == HC_W'(MAX_HOLD));
        w_release  = w_busy && (bus.done || !w_ownerReq || w_limit);
        w_forced   = w_busy && w_limit && !bus.done && w_ownerReq;
        w_nextPtr  = (r_idx == IDX_W'(N - 1)) ? '0 : r_idx + IDX_W'(1);
        w_pickPtr  = w_busy ? w_nextPtr : r_ptr;
    end

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req       (bus.req),
        .i_ptr       (w_pickPtr),
        .o_win_idx   (w_winIdx),
        .o_win_valid (w_winValid)
    );

    // FSM, rotating pointer, hold counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_idx       <= '0;
            r_valid     <= 1'b0;
            r_preempted <= 1'b0;
            r_ptr       <= '0;
            r_holdCnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_preempted <= 1'b0;
                    if (w_winValid) begin
                        r_state   <= BUSY;
                        r_grant   <= {{(N-1){1'b0}}, 1'b1} << w_winIdx;
                        r_idx     <= w_winIdx;
                        r_valid   <= 1'b1;
                        r_holdCnt <= HOLD_START;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_ptr       <= w_nextPtr;
                        r_preempted <= w_forced;
                        if (w_winValid) begin
                            r_grant   <= {{(N-1){1'b0}}, 1'b1} << w_winIdx;
                            r_idx     <= w_winIdx;
                            r_valid   <= 1'b1;
                            r_holdCnt <= HOLD_START;
                        end else begin
                            r_state   <= IDLE;
                            r_grant   <= '0;
                            r_idx     <= '0;
                            r_valid   <= 1'b0;
                            r_holdCnt <= '0;
                        end
                    end else begin
                        r_preempted <= 1'b0;
                        if ((MAX_HOLD != 0) && (r_holdCnt < HC_W'(MAX_HOLD))) begin
                            r_holdCnt <= r_holdCnt + HC_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_idx   = r_idx;
    assign bus.grant_valid = r_valid;
    assign bus.preempted   = r_preempted;

endmodule
